// File: rtl/proc_run_ctrl_pkg.sv
// Shared types and helpers for the processor run controller.
// Holds the run-state encoding and the counter-width helper used to size counters.
package proc_run_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESET = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } run_state_t;

    // Number of bits needed to hold every value from 0 to max_value (at least 1).
    function automatic int cnt_width(input int max_value);
        int w;
        w = 1;
        while ((32'sd1 <<< w) <= max_value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/proc_run_ctrl_if.sv
// Run-controller bus: start/PC inputs and reset/status outputs grouped together.
// The master modport is the controller; the slave modport is the environment
// (clock/reset source plus the cores). PROC_RUN_CTRL_BREAKPOINT_EN adds the
// breakpoint compare value and the breakpoint-hit flag.
interface proc_run_ctrl_if
    import proc_run_pkg::*;
#(
    parameter int NUM_CORES  = 1,
    parameter int PC_WIDTH   = 32,
    parameter int MAX_CYCLES = 300
);
    localparam int CNT_W = cnt_width(MAX_CYCLES);

    logic                          start;
    logic [NUM_CORES*PC_WIDTH-1:0] core_pc_i;
    logic [NUM_CORES-1:0]          core_reset_o;
    logic [NUM_CORES-1:0]          halted_o;
    logic [CNT_W-1:0]              cycle_count_o;
    logic                          busy_o;
    logic                          done_o;
    logic                          timeout_o;
`ifdef PROC_RUN_CTRL_BREAKPOINT_EN
    logic [PC_WIDTH-1:0]           bp_pc_i;
    logic                          bp_hit_o;

    modport master (
        input  start, core_pc_i, bp_pc_i,
        output core_reset_o, halted_o, cycle_count_o, busy_o, done_o, timeout_o, bp_hit_o
    );
    modport slave (
        output start, core_pc_i, bp_pc_i,
        input  core_reset_o, halted_o, cycle_count_o, busy_o, done_o, timeout_o, bp_hit_o
    );
`else
    modport master (
        input  start, core_pc_i,
        output core_reset_o, halted_o, cycle_count_o, busy_o, done_o, timeout_o
    );
    modport slave (
        output start, core_pc_i,
        input  core_reset_o, halted_o, cycle_count_o, busy_o, done_o, timeout_o
    );
`endif

endinterface

// File: rtl/proc_run_ctrl_halt_detector.sv
// Per-core halt detector: flags a core once its PC has stayed unchanged for
// HALT_STABLE consecutive compared cycles. The first active cycle after a clear
// only captures the PC. The halted flag is sticky until the next clear.
module halt_detector
    import proc_run_pkg::*;
#(
    parameter int PC_WIDTH    = 32,
    parameter int HALT_STABLE = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                active,
    input  logic [PC_WIDTH-1:0] pc,
    output logic                halted
);
    localparam int            SW       = cnt_width(HALT_STABLE);
    localparam logic [SW-1:0] SAT      = SW'(HALT_STABLE);
    localparam logic [SW-1:0] STEP_ONE = SW'(1);

    logic [PC_WIDTH-1:0] prev_pc_r;
    logic [PC_WIDTH-1:0] prev_pc_nx_s;
    logic                valid_r;
    logic                valid_nx_s;
    logic [SW-1:0]       stable_r;
    logic [SW-1:0]       stable_nx_s;
    logic                halted_r;
    logic                halted_nx_s;

    // Next-state for the previous-PC capture, stable counter and sticky flag.
    always_comb begin
        prev_pc_nx_s = prev_pc_r;
        valid_nx_s   = valid_r;
        stable_nx_s  = stable_r;
        halted_nx_s  = halted_r;
        if (clear) begin
            prev_pc_nx_s = {PC_WIDTH{1'b0}};
            valid_nx_s   = 1'b0;
            stable_nx_s  = {SW{1'b0}};
            halted_nx_s  = 1'b0;
        end else if (active) begin
            prev_pc_nx_s = pc;
            valid_nx_s   = 1'b1;
            if (!valid_r) begin
                stable_nx_s = {SW{1'b0}};
            end else if (pc == prev_pc_r) begin
                stable_nx_s = (stable_r == SAT) ? SAT : (stable_r + STEP_ONE);
            end else begin
                stable_nx_s = {SW{1'b0}};
            end
            halted_nx_s = halted_r | (stable_nx_s == SAT);
        end else begin
            prev_pc_nx_s = prev_pc_r;
        end
    end

    // Detector state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_pc_r <= {PC_WIDTH{1'b0}};
            valid_r   <= 1'b0;
            stable_r  <= {SW{1'b0}};
            halted_r  <= 1'b0;
        end else begin
            prev_pc_r <= prev_pc_nx_s;
            valid_r   <= valid_nx_s;
            stable_r  <= stable_nx_s;
            halted_r  <= halted_nx_s;
        end
    end

    assign halted = halted_r;

endmodule

// File: rtl/proc_run_ctrl.sv
// Processor run controller: holds the cores in reset for RESET_CYCLES after a
// start, runs them, and ends the run when every core has halted or the cycle
// budget is spent. Defining PROC_RUN_CTRL_BREAKPOINT_EN also ends the run
// when any core PC matches a breakpoint address.
module proc_run_ctrl
    import proc_run_pkg::*;
#(
    parameter int NUM_CORES    = 1,
    parameter int PC_WIDTH     = 32,
    parameter int RESET_CYCLES = 2,
    parameter int MAX_CYCLES   = 300,
    parameter int HALT_STABLE  = 3
) (
    input  logic           clk,
    input  logic           reset,
    proc_run_ctrl_if.master bus
);
    localparam int                CNT_W     = cnt_width(MAX_CYCLES);
    localparam int                HOLD_W    = cnt_width(RESET_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    run_state_t           state_r;
    run_state_t           state_nx_s;
    logic                 launch_s;
    logic                 run_exit_s;
    logic                 active_s;
    logic                 all_halted_s;
    logic                 budget_spent_s;
    logic                 bp_match_s;
    logic [NUM_CORES-1:0] halted_s;
    logic [HOLD_W-1:0]    hold_r;
    logic [CNT_W-1:0]     cycle_count_r;
    logic                 timeout_r;
    logic                 busy_r;
    logic                 done_r;
    logic [NUM_CORES-1:0] core_reset_r;

    assign all_halted_s   = &halted_s;
    assign budget_spent_s = (cycle_count_r == CNT_MAX);
    assign active_s       = (state_r == RUN) && !run_exit_s;

`ifdef PROC_RUN_CTRL_BREAKPOINT_EN
    logic bp_hit_r;

    // Any core sitting on the breakpoint address requests the end of the run.
    always_comb begin
        bp_match_s = 1'b0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (bus.core_pc_i[k*PC_WIDTH +: PC_WIDTH] == bus.bp_pc_i) begin
                bp_match_s = 1'b1;
            end else begin
                bp_match_s = bp_match_s;
            end
        end
    end

    // Breakpoint-hit flag: cleared on start, set when a breakpoint ends the run.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bp_hit_r <= 1'b0;
        end else if (launch_s) begin
            bp_hit_r <= 1'b0;
        end else if (run_exit_s) begin
            bp_hit_r <= !all_halted_s && bp_match_s;
        end else begin
            bp_hit_r <= bp_hit_r;
        end
    end

    assign bus.bp_hit_o = bp_hit_r;
`else
    assign bp_match_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic with the start-accept and run-exit strobes.
    always_comb begin
        state_nx_s = state_r;
        launch_s   = 1'b0;
        run_exit_s = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_nx_s = RESET;
                    launch_s   = 1'b1;
                end else begin
                    state_nx_s = state_r;
                end
            end
            RESET: begin
                if (hold_r == {HOLD_W{1'b0}}) begin
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = RESET;
                end
            end
            RUN: begin
                if (all_halted_s || bp_match_s || budget_spent_s) begin
                    state_nx_s = DONE;
                    run_exit_s = 1'b1;
                end else begin
                    state_nx_s = RUN;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Reset hold counter, RUN cycle counter and timeout flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_r        <= {HOLD_W{1'b0}};
            cycle_count_r <= {CNT_W{1'b0}};
            timeout_r     <= 1'b0;
        end else if (launch_s) begin
            hold_r        <= HOLD_INIT;
            cycle_count_r <= {CNT_W{1'b0}};
            timeout_r     <= 1'b0;
        end else begin
            if (state_r == RESET && hold_r != {HOLD_W{1'b0}}) begin
                hold_r <= hold_r - HOLD_ONE;
            end else begin
                hold_r <= hold_r;
            end
            // The exit cycle is not counted, so the count never passes MAX_CYCLES.
            if (active_s) begin
                cycle_count_r <= cycle_count_r + CNT_ONE;
            end else begin
                cycle_count_r <= cycle_count_r;
            end
            if (run_exit_s) begin
                timeout_r <= !all_halted_s && !bp_match_s;
            end else begin
                timeout_r <= timeout_r;
            end
        end
    end

    // Status and core-reset outputs, registered from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            core_reset_r <= {NUM_CORES{1'b1}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            core_reset_r <= (state_nx_s == RUN) ? {NUM_CORES{1'b0}} : {NUM_CORES{1'b1}};
            busy_r       <= (state_nx_s == RESET) || (state_nx_s == RUN);
            done_r       <= (state_nx_s == DONE);
        end
    end

    for (genvar k = 0; k < NUM_CORES; k++) begin : g_core
        halt_detector #(
            .PC_WIDTH    (PC_WIDTH),
            .HALT_STABLE (HALT_STABLE)
        ) u_halt_detector (
            .clk    (clk),
            .reset  (reset),
            .clear  (launch_s),
            .active (active_s),
            .pc     (bus.core_pc_i[k*PC_WIDTH +: PC_WIDTH]),
            .halted (halted_s[k])
        );
    end

    assign bus.core_reset_o  = core_reset_r;
    assign bus.halted_o      = halted_s;
    assign bus.cycle_count_o = cycle_count_r;
    assign bus.busy_o        = busy_r;
    assign bus.done_o        = done_r;
    assign bus.timeout_o     = timeout_r;

endmodule

// File: doc/proc_run_ctrl.md
# proc_run_ctrl

Parametrised run controller that sequences one or more processor cores through reset, run and completion. It holds each core in reset for a programmable number of cycles, then releases it. It declares a core halted when its PC stays unchanged for a set number of cycles, and ends the run on all-halted or on a cycle-budget timeout. It sits between the clock/reset source and the `Top_Single_Processor` instances in simulation and FPGA top levels, replacing fixed-delay reset and fixed-time stop.

## Interface
- `NUM_CORES`, 1: number of controlled cores.
- `PC_WIDTH`, 32: PC width per core.
- `RESET_CYCLES`, 2: cycles `core_reset_o` is held after `start` (≥1).
- `MAX_CYCLES`, 300: RUN-cycle budget before timeout (≥1).
- `HALT_STABLE`, 3: consecutive unchanged-PC cycles that mark a core halted (≥1).
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a run. Sampled in IDLE and DONE only.
- `core_pc_i`  in  NUM_CORES*PC_WIDTH  packed core PCs; core k is at `[k*PC_WIDTH +: PC_WIDTH]`.
- `core_reset_o`  out  NUM_CORES  active-high reset to each core.
- `halted_o`  out  NUM_CORES  per-core halt flag.
- `cycle_count_o`  out  $clog2(MAX_CYCLES+1)  RUN cycles elapsed.
- `busy_o`  out  1  high in RESET or RUN.
- `done_o`  out  1  high in DONE.
- `timeout_o`  out  1  run ended by budget exhaustion.

## Operation
- **States:** IDLE, RESET, RUN, DONE.
- **IDLE**
  - `core_reset_o` is all-ones.
  - `start` → RESET. The hold counter is loaded with `RESET_CYCLES-1`, and `cycle_count_o`, `halted_o` and `timeout_o` are cleared.
- **RESET**
  - `core_reset_o` is all-ones.
  - When the hold counter reaches 0 → RUN. Otherwise it decrements.
- **RUN**
  - `core_reset_o` is all-zeros. `cycle_count_o` increments by 1 every cycle.
  - Per core, the current PC is compared with the registered previous PC.
    - Equal: the stable counter increments, saturating at `HALT_STABLE`.
    - Different: the stable counter is cleared.
    - The first RUN cycle only captures the PC and performs no comparison.
  - `halted_o[k]` = stable counter k == `HALT_STABLE`. It is sticky within the run.
  - Exit conditions, evaluated each cycle on registered values:
    - All `halted_o` set → DONE with `timeout_o`=0.
    - Otherwise, `cycle_count_o` == `MAX_CYCLES` → DONE with `timeout_o`=1.
    - If both hold on the same cycle, halt wins (`timeout_o`=0).
- **DONE**
  - `core_reset_o` is all-ones.
  - `cycle_count_o`, `halted_o` and `timeout_o` hold their values for inspection.
  - `start` → RESET (same actions as from IDLE).
- `start` in RESET or RUN is ignored.
- **Async reset mid-run:** all state returns to the reset values immediately, with no partial completion reported.

## Timing
- **Reset values:**
  - state IDLE.
  - `core_reset_o` all-ones.
  - `halted_o` 0, `cycle_count_o` 0.
  - `busy_o` 0, `done_o` 0, `timeout_o` 0.
- **Run sequence:**
  - `start` high at edge n → `busy_o` and `core_reset_o` high from n through n+`RESET_CYCLES`.
  - `core_reset_o` falls after edge n+`RESET_CYCLES`.
  - The first RUN cycle ends at edge n+`RESET_CYCLES`+1, where `cycle_count_o` becomes 1.
- **Halt latency:** a PC frozen from RUN cycle c sets `halted_o` at the end of cycle c+`HALT_STABLE`. `done_o` rises one cycle later.
- **Timeout:** `done_o` rises on the edge after `cycle_count_o` reaches `MAX_CYCLES`, so RUN lasts at most `MAX_CYCLES`+1 cycles. `cycle_count_o` never exceeds `MAX_CYCLES`.
- All outputs are registered; none depend combinationally on inputs.

## Configuration
- Macro: `PROC_RUN_CTRL_BREAKPOINT_EN`.
- **Defined:**
  - Adds input `bp_pc_i` [PC_WIDTH] and output `bp_hit_o` (reset 0).
  - In RUN, if any core PC equals `bp_pc_i` → DONE next edge with `bp_hit_o`=1 and `timeout_o`=0.
  - Priority: all-halted > breakpoint > timeout.
  - `bp_hit_o` clears on the next `start`.
- **Undefined:** no extra ports; exit only on halt or timeout.

## Structure
- Package `proc_run_pkg`: state enum `run_state_t` (IDLE=0, RESET=1, RUN=2, DONE=3), and a function computing the counter width from `MAX_CYCLES`.
- Sub-module `halt_detector`, one per core via generate:
  - Inputs: `clk`, `reset`, `clear`, `active`, `pc`.
  - Output: `halted`.
  - Contents: previous-PC register, valid bit, saturating stable counter.

## Test plan
- **Basic halt:** `NUM_CORES`=1, `RESET_CYCLES`=2, `HALT_STABLE`=3. Pulse `start`; PC increments by 4 for 10 RUN cycles, then freezes at 0x28.
  - Expect `core_reset_o` high for 3 cycles after `start`.
  - Expect `halted_o`=1 after 3 frozen cycles, then `done_o`=1, `timeout_o`=0, `cycle_count_o`=14.
- **Timeout:** `MAX_CYCLES`=20, PC always changing → `done_o`=1, `timeout_o`=1, `cycle_count_o`=20, `halted_o`=0.
- **Multi-core:** `NUM_CORES`=2; core 0 freezes at cycle 5, core 1 at cycle 12.
  - `halted_o`=2'b01 from cycle 8, then 2'b11 at cycle 15.
  - `done_o` follows one cycle later.
- **Async reset mid-run:** drop `reset` at RUN cycle 7 → all outputs return immediately to reset values (`core_reset_o` all-ones, `busy_o`=0). Release, pulse `start` → clean restart with count from 0.
- **Restart and ignored start:** pulse `start` during RUN → no effect. After DONE, pulse `start` → counters and flags cleared, new RESET phase.
- **Breakpoint (macro defined):** `bp_pc_i`=0x10, PC increments by 4 from 0 → `done_o` one edge after PC reaches 0x10, with `bp_hit_o`=1 and `timeout_o`=0.
